// File: rtl/led_pkg.sv
// Shared definitions for the LED fade/PWM stage: channel count and per-channel state encoding.
package led_pkg;

    localparam int LED_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RISING  = 2'd1,
        ST_FULL    = 2'd2,
        ST_FALLING = 2'd3
    } chan_state_e;

endpackage

// File: rtl/led_fade_chan.sv
// One LED channel: brightness state machine, saturating level update and registered PWM compare.
//
//   state      | meaning
//   -----------+---------------------------------------------
//   ST_IDLE    | level is 0, channel dark
//   ST_RISING  | pattern bit on, level climbing toward MAX
//   ST_FULL    | level is MAX, channel fully lit
//   ST_FALLING | pattern bit off, level decaying toward 0
module led_fade_chan
    import led_pkg::*;
#(
    parameter int PWM_BITS  = 8,
    parameter int RISE_STEP = 64,
    parameter int FALL_STEP = 8
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                fade_en_i,
    input  logic                step_tick_i,
    input  logic                lit_i,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    output logic                pwm_o
);

    localparam int XW = PWM_BITS + 1;
    localparam logic [PWM_BITS:0]   MAX_X   = XW'((2 ** PWM_BITS) - 1);
    localparam logic [PWM_BITS:0]   RISE_X  = XW'(RISE_STEP);
    localparam logic [PWM_BITS:0]   FALL_X  = XW'(FALL_STEP);
    localparam logic [PWM_BITS-1:0] LVL_MAX = {PWM_BITS{1'b1}};

    chan_state_e         state_q;
    logic [PWM_BITS-1:0] level_q;
    logic                pwm_q;

    logic [PWM_BITS:0]   sum_x;
    logic [PWM_BITS:0]   diff_x;
    logic [PWM_BITS-1:0] rise_d;
    logic [PWM_BITS-1:0] fall_d;

    // One extra bit of headroom: overflow shows as sum > MAX, underflow as the top bit set.
    always_comb begin
        sum_x  = {1'b0, level_q} + RISE_X;
        diff_x = {1'b0, level_q} - FALL_X;
        rise_d = (sum_x > MAX_X) ? LVL_MAX : sum_x[PWM_BITS-1:0];
        fall_d = diff_x[PWM_BITS] ? '0 : diff_x[PWM_BITS-1:0];
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            level_q <= '0;
            pwm_q   <= 1'b0;
        end else begin
            pwm_q <= (pwm_cnt_i < level_q);
            if (!fade_en_i) begin
                level_q <= lit_i ? LVL_MAX : '0;
                state_q <= lit_i ? ST_FULL : ST_IDLE;
            end else if (step_tick_i) begin
                case (state_q)
                    ST_IDLE, ST_RISING, ST_FALLING: begin
                        if (lit_i) begin
                            level_q <= rise_d;
                            state_q <= (rise_d == LVL_MAX) ? ST_FULL : ST_RISING;
                        end else if (state_q != ST_IDLE) begin
                            level_q <= fall_d;
                            state_q <= (fall_d == '0) ? ST_IDLE : ST_FALLING;
                        end
                    end
                    ST_FULL: begin
                        if (!lit_i) begin
                            level_q <= fall_d;
                            state_q <= (fall_d == '0) ? ST_IDLE : ST_FALLING;
                        end
                    end
                    default: begin
                        level_q <= '0;
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/led_fade_pwm.sv
// LED fade/PWM stage: registers the pattern, runs the step and PWM counters, and drives
// one fading channel per pattern bit.
module led_fade_pwm
    import led_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int STEP_CYCLES = 50000,
    parameter int RISE_STEP   = 64,
    parameter int FALL_STEP   = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             fade_en,
    input  logic [LED_W-1:0] led_in,
    output logic             step_tick,
    output logic [LED_W-1:0] led_out
);

    localparam int MAX = (2 ** PWM_BITS) - 1;
    localparam int SW  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST  = PWM_BITS'(MAX - 1);

    logic [LED_W-1:0]    led_q;
    logic [SW-1:0]       step_cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                tick;

    // The two counters free-run independently; the PWM period is MAX cycles so level MAX is solid on.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            led_q      <= '0;
            step_cnt_q <= '0;
            pwm_cnt_q  <= '0;
        end else begin
            led_q      <= led_in;
            step_cnt_q <= (step_cnt_q == STEP_LAST) ? '0 : step_cnt_q + SW'(1);
            pwm_cnt_q  <= (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + PWM_BITS'(1);
        end
    end

    assign tick      = (step_cnt_q == STEP_LAST);
    assign step_tick = tick;

    for (genvar i = 0; i < LED_W; i++) begin : g_chan
        led_fade_chan #(
            .PWM_BITS  (PWM_BITS),
            .RISE_STEP (RISE_STEP),
            .FALL_STEP (FALL_STEP)
        ) u_chan (
            .sys_clk     (sys_clk),
            .sys_rst_n   (sys_rst_n),
            .fade_en_i   (fade_en),
            .step_tick_i (tick),
            .lit_i       (led_q[i]),
            .pwm_cnt_i   (pwm_cnt_q),
            .pwm_o       (led_out[i])
        );
    end

endmodule
